fir_mac_sequencer: RTL and testbench

- Time-multiplexed FIR controller that drives one external `alu` MAC slice.
- The slice computes `totalSumOut = inputX*inputB + totalSumIn`.
- Per accepted input sample, the block walks NTAPS taps, presenting (sample, coefficient, running sum) to the slice and chaining the returned sum back in.
- It then emits the filter output through a valid/ready handshake. It is the initiator side of the MAC interface.

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_delay_line.sv | 40 ++++
 rtl/fir_mac_sequencer.sv | 135 +++++++++++++
 tb/tb_fir_mac_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults and FSM encoding for the time-multiplexed FIR MAC sequencer.
package fir_pkg;

  localparam int NTAPS_DEFAULT   = 8;
  localparam int DW_DEFAULT      = 16;
  localparam int ACCW_DEFAULT    = 39;
  localparam int MAC_LAT_DEFAULT = 2;
  localparam int TAP_AW          = $clog2(NTAPS_DEFAULT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample history: one write port and one combinational read port
// returning x[n-k], where x[n] is the most recently written sample.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NTAPS = NTAPS_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(NTAPS)-1:0] rd_k,
  output logic [DW-1:0]            rd_data
);

  localparam int AW = $clog2(NTAPS);

  logic [DW-1:0] mem [NTAPS];
  logic [AW-1:0] wptr;

  // wptr points at the next free slot, so the newest sample sits at wptr-1;
  // the AW-bit subtraction gives the modulo-NTAPS wrap for free.
  assign rd_data = mem[wptr - AW'(1) - rd_k];

  // NOTE: state updates use non-blocking (<=) so every register samples
  // pre-edge values, independent of statement order.
  // NOTE: the history is reset explicitly because startup outputs must see
  // zero history; a plain RAM would otherwise come up with garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + AW'(1);
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller driving one external multiply-accumulate slice, one tap at a
// time. Optional build macro: FIR_SKIP_ZERO_EN (zero-coefficient taps take 1 cycle).
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NTAPS   = NTAPS_DEFAULT,
  parameter int DW      = DW_DEFAULT,
  parameter int ACCW    = ACCW_DEFAULT,
  parameter int MAC_LAT = MAC_LAT_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            sample_in,
  input  logic                     sample_valid,
  output logic                     sample_ready,
  input  logic                     coef_wr_en,
  input  logic [$clog2(NTAPS)-1:0] coef_wr_addr,
  input  logic [DW-1:0]            coef_wr_data,
  output logic [DW-1:0]            mac_x,
  output logic [DW-1:0]            mac_b,
  output logic [ACCW-1:0]          mac_sum_in,
  input  logic [ACCW-1:0]          mac_sum_out,
  output logic [ACCW-1:0]          y_out,
  output logic                     y_valid,
  input  logic                     y_ready
);

  localparam int AW = $clog2(NTAPS);
  localparam int CW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  logic [1:0]      state;
  logic [AW-1:0]   k;
  logic [CW-1:0]   cnt;
  logic [ACCW-1:0] acc;
  logic [DW-1:0]   coef [NTAPS];
  logic [DW-1:0]   tap_x;
  logic            accept;
  logic            last_tap;
  logic            skip_tap;

  // Gated by rst so the reset cycles themselves never advertise readiness.
  assign sample_ready = (state == IDLE) && !rst;
  assign accept       = sample_valid && sample_ready;
  assign last_tap     = (k == AW'(NTAPS - 1));

`ifdef FIR_SKIP_ZERO_EN
  assign skip_tap = (state == RUN) && (coef[k] == '0);
`else
  assign skip_tap = 1'b0;
`endif

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (sample_in),
    .rd_k    (k),
    .rd_data (tap_x)
  );

  // NOTE: every output gets a default before the if, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    mac_x      = '0;
    mac_b      = '0;
    mac_sum_in = '0;
    if (state == RUN && !skip_tap) begin
      mac_x      = tap_x;
      mac_b      = coef[k];
      mac_sum_in = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      cnt     <= '0;
      acc     <= '0;
      y_out   <= '0;
      y_valid <= 1'b0;
      for (int i = 0; i < NTAPS; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The address width spans exactly NTAPS entries, so every write
          // lands on a real tap; coefficients only change between samples.
          if (coef_wr_en) coef[coef_wr_addr] <= coef_wr_data;
          if (accept) begin
            k     <= '0;
            cnt   <= '0;
            acc   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          if (skip_tap) begin
            k <= k + AW'(1);
            if (last_tap) begin
              y_out   <= acc;
              y_valid <= 1'b1;
              state   <= OUT;
            end
          end else if (cnt == CW'(MAC_LAT)) begin
            // Slice output is settled after MAC_LAT edges of stable inputs.
            acc <= mac_sum_out;
            cnt <= '0;
            k   <= k + AW'(1);
            if (last_tap) begin
              y_out   <= mac_sum_out;
              y_valid <= 1'b1;
              state   <= OUT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: behavioural MAC slice plus a sum-of-products reference
// model over the sample history; table vectors, corner sequences, random run.
module tb_fir_mac_sequencer;

  localparam int NTAPS   = 8;
  localparam int DW      = 16;
  localparam int ACCW    = 39;
  localparam int MAC_LAT = 2;
  localparam int AW      = $clog2(NTAPS);

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   sample_in;
  logic            sample_valid;
  logic            sample_ready;
  logic            coef_wr_en;
  logic [AW-1:0]   coef_wr_addr;
  logic [DW-1:0]   coef_wr_data;
  logic [DW-1:0]   mac_x;
  logic [DW-1:0]   mac_b;
  logic [ACCW-1:0] mac_sum_in;
  logic [ACCW-1:0] mac_sum_out;
  logic [ACCW-1:0] y_out;
  logic            y_valid;
  logic            y_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .NTAPS(NTAPS), .DW(DW), .ACCW(ACCW), .MAC_LAT(MAC_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .mac_x(mac_x), .mac_b(mac_b), .mac_sum_in(mac_sum_in), .mac_sum_out(mac_sum_out),
    .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready)
  );

  // Two-stage MAC slice: result valid MAC_LAT=2 edges after inputs appear.
  logic [ACCW-1:0] mac_p1, mac_p2;
  always @(posedge clk) begin
    mac_p1 <= ACCW'(mac_x) * ACCW'(mac_b) + mac_sum_in;
    mac_p2 <= mac_p1;
  end
  assign mac_sum_out = mac_p2;

  // Reference model: history newest-first, y = sum coef[k]*x[n-k] mod 2^ACCW.
  logic [DW-1:0] hist_m [NTAPS];
  logic [DW-1:0] coef_m [NTAPS];

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) begin
      hist_m[i] = '0;
      coef_m[i] = '0;
    end
  endfunction

  function automatic void model_push(input logic [DW-1:0] x);
    for (int i = NTAPS - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = x;
  endfunction

  function automatic logic [ACCW-1:0] model_y();
    logic [ACCW-1:0] s = '0;
    for (int i = 0; i < NTAPS; i++) s += ACCW'(coef_m[i]) * ACCW'(hist_m[i]);
    return s;
  endfunction

  function automatic int model_lat();
    int n = 0;
    for (int i = 0; i < NTAPS; i++) begin
`ifdef FIR_SKIP_ZERO_EN
      n += (coef_m[i] == '0) ? 1 : MAC_LAT + 1;
`else
      n += MAC_LAT + 1;
`endif
    end
    return n;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_valid = 1'b0; coef_wr_en = 1'b0; y_ready = 1'b0;
    sample_in = '0; coef_wr_addr = '0; coef_wr_data = '0;
    step(); step();
    check("rst_sample_ready", sample_ready, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_mac_x", mac_x, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_mac_sum_in", mac_sum_in, 0);
    rst = 1'b0;
    model_reset();
    step();
    check("post_rst_ready", sample_ready, 1);
  endtask

  task automatic write_coef(input int a, input logic [DW-1:0] d);
    coef_wr_en = 1'b1; coef_wr_addr = AW'(a); coef_wr_data = d;
    step();
    coef_wr_en = 1'b0;
    coef_m[a] = d;
  endtask

  // Accept one sample, wait for the result, check latency/value, optionally
  // stall the output handshake and optionally poke a coefficient mid-RUN.
  task automatic send_sample(input logic [DW-1:0] x, input int stall, input bit mid_wr,
                             output logic [ACCW-1:0] y);
    int lat = 0;
    bit ready_bad = 0, hold_bad = 0;
    logic [ACCW-1:0] exp_y;
    int exp_lat;
    for (int i = 0; i < 50 && !sample_ready; i++) step();
    sample_in = x; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    model_push(x);
    exp_y = model_y();
    exp_lat = model_lat();
    while (!y_valid && lat < 1000) begin
      coef_wr_en = mid_wr && (lat == 5);
      coef_wr_addr = '0; coef_wr_data = 16'h1234;
      if (sample_ready) ready_bad = 1;
      step();
      lat++;
    end
    coef_wr_en = 1'b0;
    check("latency", lat, exp_lat);
    check("y_out", y_out, exp_y);
    y = y_out;
    for (int i = 0; i < stall; i++) begin
      step();
      if (y_out !== y || y_valid !== 1'b1) hold_bad = 1;
      if (sample_ready) ready_bad = 1;
    end
    check("ready_low_busy", ready_bad, 0);
    if (stall > 0) check("out_hold_stable", hold_bad, 0);
    y_ready = 1'b1;
    step();
    y_ready = 1'b0;
    if (stall > 0 || mid_wr) begin
      check("y_valid_drop", y_valid, 0);
      check("ready_after_out", sample_ready, 1);
    end
  endtask

  typedef struct {
    logic [DW-1:0]   x;
    logic [ACCW-1:0] y;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ACCW-1:0] y;

    tbl[0] = '{16'd7, 39'd21};
    tbl[1] = '{16'd9, 39'd27};
    tbl[2] = '{16'd1, 39'd1};
    for (int i = 1; i < 8; i++) tbl[2+i] = '{16'd0, ACCW'(i + 1)};
    for (int i = 8; i < 12; i++) tbl[2+i] = '{16'd0, 39'd0};

    // 1: cleared coefficients give zero, plus handshake timing
    do_reset();
    send_sample(16'd5, 0, 1'b0, y);
    check("t1_ready_next", sample_ready, 1);
    check("t1_y_valid_low", y_valid, 0);

    // 2: single nonzero tap
    do_reset();
    write_coef(0, 16'd3);
    for (int i = 0; i < 2; i++) begin
      send_sample(tbl[i].x, 0, 1'b0, y);
      check("t2_table", y, tbl[i].y);
    end

    // 3: impulse response then flush
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, DW'(i + 1));
    for (int i = 2; i < 14; i++) begin
      send_sample(tbl[i].x, 0, 1'b0, y);
      check("t3_table", y, tbl[i].y);
    end

    // 4: full-scale accumulation
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'hFFFF);
    for (int i = 0; i < 8; i++) send_sample(16'hFFFF, 0, 1'b0, y);
    check("t4_full_scale", y, 39'h7_FFF0_0008);

    // 5: output stall plus ignored coefficient write during RUN
    do_reset();
    write_coef(0, 16'd2);
    send_sample(16'd5, 10, 1'b1, y);
    check("t5_stalled", y, 39'd10);
    send_sample(16'd1, 0, 1'b0, y);
    check("t5_old_coef", y, 39'd2);

    // 6: reset in the middle of RUN
    do_reset();
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'd1);
    send_sample(16'd9, 0, 1'b0, y);
    sample_in = 16'd8; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (9) step();
    check("t6_mac_b_run", mac_b, 1);
    rst = 1'b1;
    step();
    check("t6_abort_y_valid", y_valid, 0);
    check("t6_abort_mac_x", mac_x, 0);
    check("t6_abort_mac_b", mac_b, 0);
    check("t6_abort_mac_sum", mac_sum_in, 0);
    check("t6_abort_ready", sample_ready, 0);
    step();
    rst = 1'b0;
    model_reset();
    step();
    check("t6_ready", sample_ready, 1);
    send_sample(16'd6, 0, 1'b0, y);
    check("t6_coef_cleared", y, 39'd0);
    write_coef(0, 16'd3);
    send_sample(16'd4, 0, 1'b0, y);
    check("t6_single_tap", y, 39'd12);
    for (int i = 0; i < NTAPS; i++) write_coef(i, 16'd1);
    send_sample(16'd0, 0, 1'b0, y);
    check("t6_history_cleared", y, 39'd10);

    // Random coefficients (some zero), samples and output stalls
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NTAPS; i++)
        write_coef(i, ($urandom_range(3) == 0) ? DW'(0) : DW'($urandom()));
      for (int j = 0; j < 8; j++)
        send_sample(DW'($urandom()), int'($urandom_range(3)), 1'b0, y);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
